// File: rtl/vec_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mem_sequencer_pkg
//  Purpose  : Shared constants for the vector LW/SW element sequencer:
//             FSM state encodings, default unit word stride and the default
//             maximum vector length.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vec_mem_sequencer_pkg;

  // Sequencer FSM encodings
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACCESS = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  // Byte stride between consecutive elements of a unit-stride word access
  localparam int c_WORD_STRIDE = 4;

  // One element per vector lane; the execute stage and the vector register
  // file size themselves from the same value.
  localparam int c_MAX_VLEN = 8;

endpackage : vec_mem_sequencer_pkg
`default_nettype wire

// File: rtl/vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mem_sequencer
//  Purpose  : Sequences the elements of a vector LW/SW. One memory word access
//             is issued per element; the element counter cnt feeds the execute
//             stage and stall holds fetch/decode until the op retires.
//  Config   : VEC_MEM_STRIDE_EN - when defined, adds input `stride` (bytes,
//             captured with start). Otherwise elements are 4 bytes apart.
//  Ports    : clk, rst (async, active-high)
//             start, is_store, base_addr, rd_addr, vlen  - issue from decode
//             [stride]                                   - optional stride
//             mem_ready                                  - access completed
//             cnt, stall                                 - to execute / front end
//             mem_req, mem_we, mem_addr                  - data-memory port
//             vreg_addr                                  - element register index
//             done                                       - one-cycle retire pulse
//  Revision : 1.0  initial release
// ============================================================================
module vec_mem_sequencer
  import vec_mem_sequencer_pkg::*;
#(
  parameter int MAX_VLEN = c_MAX_VLEN,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_store,
  input  logic [31:0]       base_addr,
  input  logic [4:0]        rd_addr,
  input  logic [31:0]       vlen,
`ifdef VEC_MEM_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  cnt,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [4:0]        vreg_addr,
  output logic              done
);

  localparam logic [31:0]      c_MAX_VLEN_32 = 32'(MAX_VLEN);
  localparam logic [CNT_W-1:0] c_MAX_VLEN_CW = CNT_W'(MAX_VLEN);

  // Element count actually executed: zero stays zero, oversize requests are
  // clamped to the number of lanes (unsigned compare on the full 32 bits).
  function automatic logic [CNT_W-1:0] clamp_vlen(input logic [31:0] v);
    if (v == 32'd0)
      return '0;
    else if (v > c_MAX_VLEN_32)
      return c_MAX_VLEN_CW;
    else
      return v[CNT_W-1:0];
  endfunction

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_n;
  logic [4:0]        r_rd;
  logic              r_we;
  logic              r_stall;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_done;
  logic [ADDR_W-1:0] w_stride;
  logic [CNT_W-1:0]  w_n;

  assign w_n = clamp_vlen(vlen);

  // Only the low ADDR_W bits of the byte address reach the memory port.
  logic w_unused_base;
  assign w_unused_base = &{1'b0, base_addr[31:ADDR_W]};

`ifdef VEC_MEM_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stride <= '0;
    else if (r_state == c_ST_IDLE && start)
      r_stride <= stride;
  end

  assign w_stride = r_stride;
`else
  assign w_stride = ADDR_W'(c_WORD_STRIDE);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_cnt      <= '0;
      r_n        <= '0;
      r_rd       <= '0;
      r_we       <= 1'b0;
      r_stall    <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          // mem_ready is meaningless here; only start is looked at.
          if (start) begin
            r_we       <= is_store;
            r_rd       <= rd_addr;
            r_n        <= w_n;
            r_mem_addr <= base_addr[ADDR_W-1:0];
            r_stall    <= 1'b1;
            if (w_n != '0) begin
              r_state   <= c_ST_ACCESS;
              r_cnt     <= CNT_W'(1);
              r_mem_req <= 1'b1;
            end else begin
              // Empty vector: retire straight away without touching memory.
              r_state <= c_ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        c_ST_ACCESS: begin
          // Address/count hold until the memory completes the element.
          if (mem_ready) begin
            if (r_cnt == r_n) begin
              r_state   <= c_ST_DONE;
              r_cnt     <= '0;
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_cnt      <= r_cnt + CNT_W'(1);
              r_mem_addr <= r_mem_addr + w_stride;
            end
          end
        end

        c_ST_DONE: begin
          r_state <= c_ST_IDLE;
          r_done  <= 1'b0;
          r_stall <= 1'b0;
        end

        default: begin
          r_state   <= c_ST_IDLE;
          r_cnt     <= '0;
          r_mem_req <= 1'b0;
          r_done    <= 1'b0;
          r_stall   <= 1'b0;
        end
      endcase
    end
  end

  assign cnt      = r_cnt;
  assign stall    = r_stall;
  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;
  assign done     = r_done;
  assign mem_we   = r_we & r_mem_req;
  // cnt is 1-based while active; an idle counter maps to register 0.
  assign vreg_addr = (r_cnt != '0) ? (r_rd + 5'(r_cnt) - 5'd1) : 5'd0;

endmodule : vec_mem_sequencer
`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_mem_sequencer
//  Purpose  : Self-checking bench for vec_mem_sequencer. Each vector op is
//             predicted from its issue fields alone: N elements, element k at
//             base + k*stride and register (rd + k) mod 32, one element
//             consumed per cycle in which mem_ready is high.
//  Config   : VEC_MEM_STRIDE_EN selects the strided build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [31:0] base_addr;
  logic [4:0]  rd_addr;
  logic [31:0] vlen;
  logic        mem_ready;
  logic [15:0] stride;
  logic [4:0]  cnt;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [4:0]  vreg_addr;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vec_mem_sequencer #(.MAX_VLEN(8), .ADDR_W(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .rd_addr   (rd_addr),
    .vlen      (vlen),
`ifdef VEC_MEM_STRIDE_EN
    .stride    (stride),
`endif
    .mem_ready (mem_ready),
    .cnt       (cnt),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .vreg_addr (vreg_addr),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".cnt"},  64'(cnt), 64'd0);
    chk({tag, ".req"},  64'(mem_req), 64'd0);
    chk({tag, ".we"},   64'(mem_we), 64'd0);
    chk({tag, ".stl"},  64'(stall), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  // Issue one vector op and follow it to retirement. ready_pct is the chance
  // that memory completes an access in a given cycle. abort_at > 0 resets the
  // DUT once that many elements have been seen active.
  task automatic run_op(input logic st, input logic [31:0] base, input logic [4:0] rd,
                        input logic [31:0] vl, input logic [15:0] strd,
                        input int ready_pct, input bit poke_start, input int abort_at);
    int n;
    int k;
    int cycles;
    bit rdy;
    logic [15:0] step;
    logic [15:0] exp_addr;
`ifdef VEC_MEM_STRIDE_EN
    step = strd;
`else
    step = 16'd4;
`endif
    if (vl == 0)      n = 0;
    else if (vl > 8)  n = 8;
    else              n = int'(vl);

    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    rd_addr   = rd;
    vlen      = vl;
    stride    = strd;
    mem_ready = 1'($urandom_range(0, 1));  // must be ignored while idle
    @(posedge clk); #1;
    start = 1'b0;

    if (n == 0) begin
      chk("zero.done", 64'(done), 64'd1);
      chk("zero.req",  64'(mem_req), 64'd0);
      chk("zero.cnt",  64'(cnt), 64'd0);
      chk("zero.stl",  64'(stall), 64'd1);
    end else begin
      k = 0;
      cycles = 0;
      while (k < n && cycles < 400) begin
        exp_addr = base[15:0] + 16'(k) * step;
        chk("el.req",  64'(mem_req), 64'd1);
        chk("el.cnt",  64'(cnt), 64'(k + 1));
        chk("el.addr", 64'(mem_addr), 64'(exp_addr));
        chk("el.vreg", 64'(vreg_addr), 64'((int'(rd) + k) % 32));
        chk("el.we",   64'(mem_we), 64'(st));
        chk("el.stl",  64'(stall), 64'd1);
        chk("el.done", 64'(done), 64'd0);
        if (abort_at > 0 && k + 1 == abort_at) begin
          rst = 1'b1;
          #2;
          chk_idle_outputs("rst.async");
          chk("rst.addr", 64'(mem_addr), 64'd0);
          chk("rst.vreg", 64'(vreg_addr), 64'd0);
          @(posedge clk); #1;
          chk_idle_outputs("rst.held");
          rst = 1'b0;
          @(posedge clk); #1;
          chk_idle_outputs("rst.after");
          return;
        end
        // A second issue pulse mid-op must be ignored.
        start = (poke_start && cycles == 1);
        if (start) begin
          is_store  = ~st;
          base_addr = $urandom;
          rd_addr   = 5'($urandom);
          vlen      = 32'($urandom_range(1, 8));
          stride    = 16'($urandom);
        end
        rdy = ($urandom_range(0, 99) < ready_pct);
        mem_ready = rdy;
        @(posedge clk); #1;
        start = 1'b0;
        if (rdy) k++;
        cycles++;
      end
      chk("el.timeout", 64'(k), 64'(n));
      chk("ret.done", 64'(done), 64'd1);
      chk("ret.req",  64'(mem_req), 64'd0);
      chk("ret.cnt",  64'(cnt), 64'd0);
      chk("ret.stl",  64'(stall), 64'd1);
    end
    mem_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk_idle_outputs("idle");
    mem_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = '0;
    rd_addr   = '0;
    vlen      = '0;
    mem_ready = 1'b0;
    stride    = 16'd4;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk("reset.addr", 64'(mem_addr), 64'd0);
    chk("reset.vreg", 64'(vreg_addr), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-length load, memory always ready
    run_op(1'b0, 32'h0000_0100, 5'd8, 32'd8, 16'd4, 100, 1'b0, 0);
    // Short store with a slow memory
    run_op(1'b1, 32'h0000_0200, 5'd3, 32'd3, 16'd4, 33, 1'b0, 0);
    // Empty and oversize requests
    run_op(1'b0, 32'h0000_0300, 5'd0, 32'd0, 16'd4, 100, 1'b0, 0);
    run_op(1'b0, 32'h0000_0400, 5'd1, 32'd100, 16'd4, 100, 1'b0, 0);
    run_op(1'b1, 32'h0000_0400, 5'd1, 32'hFFFF_FFFF, 16'd4, 70, 1'b0, 0);
    // Register index and address wrap-around
    run_op(1'b0, 32'h0000_FFFC, 5'd30, 32'd4, 16'd4, 100, 1'b0, 0);
    // Strided access with an ignored mid-op issue pulse
    run_op(1'b0, 32'h0000_0020, 5'd2, 32'd4, 16'h0010, 100, 1'b1, 0);
    run_op(1'b1, 32'h0000_0040, 5'd5, 32'd3, 16'h0000, 60, 1'b0, 0);
    // Reset mid-op, then a normal op afterwards
    run_op(1'b0, 32'h0000_0500, 5'd4, 32'd8, 16'd4, 100, 1'b0, 3);
    run_op(1'b1, 32'h0000_0600, 5'd9, 32'd5, 16'd4, 100, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] vl;
      int pct;
      vl  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 10));
      pct = ($urandom_range(0, 2) == 0) ? 100 : int'($urandom_range(20, 90));
      run_op(1'($urandom), $urandom, 5'($urandom), vl, 16'($urandom),
             pct, 1'($urandom), 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_vec_mem_sequencer
`default_nettype wire
